// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the one-hot select of the 16x32 result mux.
// Grants are held while requested, with a bounded hold that forces rotation.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] req_mask,
  output logic [15:0] select,
  output logic [3:0]  grant_id,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [15:0]      select_nxt;
  logic [3:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [15:0]      ereq, others;
  logic [3:0]       owner;

  // First set bit of r scanning start, start+1, ... with 4-bit wraparound.
  function automatic logic [15:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
    logic [15:0] g;
    logic        found;
    logic [3:0]  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && r[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [3:0] encode(input logic [15:0] oh);
    logic [3:0] id;
    id = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) id = id | 4'(i);
    end
    return id;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      select   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      select   <= select_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    ereq       = req & req_mask;
    owner      = encode(select);
    others     = ereq & ~select;
    state_nxt  = state;
    select_nxt = select;
    ptr_nxt    = ptr;
    cnt_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (|ereq) begin
          select_nxt = rr_pick(ereq, ptr);
          cnt_nxt    = '0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        // Release and preempt both hand off to the other requesters from owner+1.
        if (!ereq[owner] || (hold_cnt == HOLD_LAST && |others)) begin
          ptr_nxt    = owner + 4'd1;
          select_nxt = rr_pick(others, owner + 4'd1);
          cnt_nxt    = '0;
          state_nxt  = (|others) ? GRANT : IDLE;
        end else if (hold_cnt != HOLD_LAST) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        select_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_id = encode(select);
    busy     = |select;
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed literal cases from the
// test plan plus randomized traffic compared each cycle against a behavioural model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] req_mask = 16'hFFFF;
  logic [15:0] select;
  logic [3:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_mask (req_mask),
    .select   (select),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: owner index (-1 = idle), priority pointer, hold cycles.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  function automatic int pick(input logic [15:0] v, input int start);
    for (int k = 0; k < 16; k++) begin
      if (v[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] e, oth;
    if (!rst_n) begin
      m_own <= -1;
      m_ptr <= 0;
      m_cnt <= 0;
    end else begin
      e = req & req_mask;
      if (m_own < 0) begin
        if (e != 0) begin
          m_own <= pick(e, m_ptr);
          m_cnt <= 0;
        end
      end else begin
        oth = e;
        oth[m_own] = 1'b0;
        if (e[m_own] && !(m_cnt == MAX_HOLD - 1 && oth != 0)) begin
          m_cnt <= (m_cnt + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_cnt + 1;
        end else begin
          m_ptr <= (m_own + 1) % 16;
          m_own <= pick(oth, (m_own + 1) % 16);
          m_cnt <= 0;
        end
      end
    end
  end

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_select", select, (m_own < 0) ? 32'h0 : (32'h1 << m_own));
      check("model_grant_id", grant_id, (m_own < 0) ? 32'h0 : 32'(m_own));
      check("model_busy", busy, (m_own < 0) ? 32'h0 : 32'h1);
      check("onehot0", $onehot0(select), 1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req      = '0;
    req_mask = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("reset_select", select, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single request, then drop.
    req = 16'h0001;
    @(negedge clk);
    check("single_select", select, 16'h0001);
    check("single_grant_id", grant_id, 0);
    check("single_busy", busy, 1);
    req = 16'h0000;
    @(negedge clk);
    check("single_drop", select, 16'h0000);

    // Fairness: 8 cycles each, alternating ch0 / ch15.
    do_reset();
    req = 16'h8001;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      check("fair_select", select, (((k - 1) / 8) % 2 == 0) ? 16'h0001 : 16'h8000);
    end
    req = 16'h0000;

    // Wrap: ch15 releases while ch0 and ch4 request -> ch0, no idle cycle.
    do_reset();
    req = 16'h8000;
    @(negedge clk);
    check("wrap_owner", select, 16'h8000);
    req = 16'h0011;
    @(negedge clk);
    check("wrap_select", select, 16'h0001);
    check("wrap_busy", busy, 1);

    // Sole holder keeps the grant; a late contender preempts via the saturated count.
    do_reset();
    req = 16'h0100;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      check("sole_select", select, 16'h0100);
    end
    req = 16'h0104;
    @(negedge clk);
    check("sole_preempt", select, 16'h0004);

    // Mask removes the owner.
    do_reset();
    req = 16'h0008;
    @(negedge clk);
    check("mask_owner", select, 16'h0008);
    req      = 16'h0018;
    req_mask = 16'hFFF7;
    @(negedge clk);
    check("mask_select", select, 16'h0010);
    check("mask_grant_id", grant_id, 4);
    req = 16'h0008;
    @(negedge clk);
    check("mask_idle_busy", busy, 0);
    check("mask_idle_select", select, 0);
    req_mask = 16'hFFFF;

    // Asynchronous reset mid-cycle.
    do_reset();
    req = 16'h0020;
    @(negedge clk);
    check("async_owner", select, 16'h0020);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_select", select, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    req   = 16'hFFFF;
    rst_n = 1'b1;
    @(negedge clk);
    check("async_after", select, 16'h0001);

    // Randomized traffic with slowly changing requests and masks.
    do_reset();
    req = 16'($urandom);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) req_mask[$urandom_range(0, 15)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) req = '0;
      if ($urandom_range(0, 199) == 0) req_mask = 16'hFFFF;
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter that shares the 16-channel x 32-bit one-hot result mux among 16 requesting units.
- Produces the registered one-hot `select` vector driving the mux, plus an encoded owner index and a busy flag.
- Each grant is held while its requester keeps requesting, bounded by a hold limit that forces rotation when others are waiting.
- Sits between the ALU functional units (requesters) and the mux select input.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while another unmasked request is pending; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request per channel; bit i = unit i wants the mux.
- req_mask  input  16  1 = channel enabled; masked requests are ignored as if low.
- select  output  16  registered one-hot grant, wired directly to the mux select; all-zero when idle.
- grant_id  output  4  binary index of the set bit of select; 0 when idle.
- busy  output  1  1 when select is non-zero.

Behaviour:
- Reset (async assert, sync release): select=0, grant_id=0, busy=0, FSM=IDLE, priority pointer ptr=0, hold_cnt=0.
- Effective request: ereq = req & req_mask, sampled at each rising edge.
- Winner: the first set bit of ereq scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16). Computed from current-cycle ereq.
- Invariant: select is always zero or exactly one-hot; grant_id and busy are derived from the same register, with no skew.
- IDLE:
  - If ereq != 0: next edge loads select = onehot(winner), hold_cnt=0, FSM goes to GRANT. Latency req->select is 1 cycle.
  - Else stay in IDLE.
- GRANT, owner o:
  - **Release:** if ereq[o]=0 (dropped or masked), then ptr <= o+1 mod 16.
    - If some other ereq bit is set, select moves directly to the winner computed with the new pointer on the same edge, with no idle cycle and hold_cnt=0.
    - Else select=0 and FSM goes to IDLE.
  - **Preempt:** if ereq[o]=1, hold_cnt = MAX_HOLD-1, and any other ereq bit is set, then ptr <= o+1 and select moves to the winner among the other requesters on the same edge; hold_cnt=0. The preempted owner re-enters arbitration normally.
  - **Hold:** if ereq[o]=1 with no preempt condition, select is unchanged and hold_cnt increments.
    - hold_cnt saturates at MAX_HOLD-1 when the owner is the sole requester, so it keeps the grant indefinitely.
- MAX_HOLD=1: each owner gets exactly one cycle whenever contention exists.
- Simultaneous release and new request by another channel in the same cycle: handled by the release rule (back-to-back grant).
- A new request from a channel other than the owner never changes select except via release or preempt.
- ptr updates only on release or preempt; it never advances while IDLE.
- Reset asserted mid-grant: select clears immediately (asynchronously), and ptr returns to 0.

Test Plan:
- Reset then req=0x0001, mask=0xFFFF -> select=0x0001, grant_id=0, busy=1 one cycle later; drop req -> select=0x0000 next cycle.
- Fairness: req=0x8001 held constant, MAX_HOLD=8 -> grant sequence ch0 for 8 cycles, ch15 for 8 cycles, ch0 for 8 cycles, alternating; never two one-hot bits set.
- Wrap priority: ch15 owns and releases while req=0x0011 -> next edge select=0x0001 (ptr wrapped to 0), no idle cycle.
- Sole holder: req=0x0100 for 300 cycles -> select=0x0100 throughout (no preempt with counter saturated); then raise req bit 2 -> select=0x0004 on the next edge.
- Mask: ch3 owns, req_mask bit 3 cleared while req=0x0018 -> next edge select=0x0010, grant_id=4; with req=0x0008 only -> idle, busy=0.
- Async reset: assert rst_n=0 mid-cycle while select=0x0020 -> select=0, busy=0 before the next clk edge; after release, req=0xFFFF -> select=0x0001.
